// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage MIPS-style pipeline: operand forwarding, load-use
// and divider interlocks, PC source selection and the multi-cycle divider sequencer.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       exe_wreg,
  input  logic       exe_load,
  input  logic [4:0] exe_rd,
  input  logic       mem_wreg,
  input  logic       mem_load,
  input  logic [4:0] mem_rd,
  input  logic       id_div,
  input  logic       id_hilo,
  input  logic       id_branch,
  input  logic       id_jump,
  input  logic       id_jr,
  input  logic       exc_req,
  input  logic       eret_req,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic [2:0] pc_sel,
  output logic       stall,
  output logic       flush_id,
  output logic       bubble_exe,
  output logic       div_start,
  output logic       div_busy
);

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EXE_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_JUMP   = 3'b010;
  localparam logic [2:0] PC_JR     = 3'b011;
  localparam logic [2:0] PC_EXC    = 3'b100;
  localparam logic [2:0] PC_ERET   = 3'b101;

  localparam int             CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_start_q, div_start_d;
  logic             div_busy_q, div_busy_d;

  logic load_use;
  logic run_active;
  logic div_stall;

  // A load in EXE has no data yet, so it is never a forwarding source; the
  // matching instruction waits one cycle and picks the value up from MEM.
  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] src,
    input logic       e_wreg,
    input logic       e_load,
    input logic [4:0] e_rd,
    input logic       m_wreg,
    input logic       m_load,
    input logic [4:0] m_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && e_wreg && !e_load && (e_rd != 5'd0) && (e_rd == src)) begin
      sel = FWD_EXE_ALU;
    end else if (use_src && m_wreg && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = m_load ? FWD_MEM_LD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

  assign fwd_rs_sel = fwd_sel(id_use_rs, id_rs, exe_wreg, exe_load, exe_rd,
                              mem_wreg, mem_load, mem_rd);
  assign fwd_rt_sel = fwd_sel(id_use_rt, id_rt, exe_wreg, exe_load, exe_rd,
                              mem_wreg, mem_load, mem_rd);

  assign load_use = exe_wreg && exe_load && (exe_rd != 5'd0) &&
                    ((id_use_rs && (exe_rd == id_rs)) ||
                     (id_use_rt && (exe_rd == id_rt)));

  // While reset is held the sequencer is treated as idle, so a divide that
  // is being killed cannot keep the pipeline frozen.
  assign run_active = div_busy_q && !rst;
  assign div_stall  = run_active && (id_hilo || id_div);

  assign stall      = load_use || div_stall;
  assign bubble_exe = stall || exc_req;
  assign flush_id   = exc_req || eret_req;

  always_comb begin
    pc_sel = PC_SEQ;
    if (exc_req)        pc_sel = PC_EXC;
    else if (eret_req)  pc_sel = PC_ERET;
    else if (stall)     pc_sel = PC_SEQ;
    else if (id_jr)     pc_sel = PC_JR;
    else if (id_jump)   pc_sel = PC_JUMP;
    else if (id_branch) pc_sel = PC_BRANCH;
  end

  // DONE accepts a new divide exactly like IDLE; it only marks the single
  // cycle in which the quotient becomes readable.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_start_d = 1'b0;
    div_busy_d  = 1'b0;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (id_div && !load_use && !exc_req) begin
          state_d     = DIV_RUN;
          cnt_d       = CNT_LOAD;
          div_start_d = 1'b1;
          div_busy_d  = 1'b1;
        end
      end
      DIV_RUN: begin
        if (exc_req) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          div_busy_d = 1'b1;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // div_start is registered, so it is seen in the first RUN cycle, i.e.
  // while the accepted divide sits in EXE.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      div_start_q <= 1'b0;
      div_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_start_q <= div_start_d;
      div_busy_q  <= div_busy_d;
    end
  end

  assign div_start = div_start_q;
  assign div_busy  = div_busy_q;

endmodule
